// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALUdec/ALU pair with a single-entry result register.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.

package alu_arbiter_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_COPY_B
  } alu_op_e;
endpackage

module ALUdec
  import alu_arbiter_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct_i,
  input  logic       add_rshift_type_i,
  output alu_op_e    alu_op_o
);
  always_comb begin
    alu_op_o = ALU_ADD;
    case (opcode_i)
      7'b0110011, 7'b0010011: begin
        case (funct_i)
          // Immediate adds have no SUB form; the type bit only matters for R-type here.
          3'b000:  alu_op_o = (opcode_i == 7'b0110011 && add_rshift_type_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op_o = ALU_SLL;
          3'b010:  alu_op_o = ALU_SLT;
          3'b011:  alu_op_o = ALU_SLTU;
          3'b100:  alu_op_o = ALU_XOR;
          3'b101:  alu_op_o = add_rshift_type_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op_o = ALU_OR;
          default: alu_op_o = ALU_AND;
        endcase
      end
      7'b0110111: alu_op_o = ALU_COPY_B;
      default:    alu_op_o = ALU_ADD;
    endcase
  end
endmodule

module ALU
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] a_i,
  input  logic [DWIDTH-1:0] b_i,
  input  alu_op_e           alu_op_i,
  output logic [DWIDTH-1:0] out_o
);
  localparam int unsigned SHW = $clog2(DWIDTH);
  logic [SHW-1:0] shamt;
  assign shamt = b_i[SHW-1:0];

  always_comb begin
    out_o = '0;
    case (alu_op_i)
      ALU_ADD:    out_o = a_i + b_i;
      ALU_SUB:    out_o = a_i - b_i;
      ALU_SLL:    out_o = a_i << shamt;
      ALU_SLT:    out_o = {{(DWIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU:   out_o = {{(DWIDTH-1){1'b0}}, (a_i < b_i)};
      ALU_XOR:    out_o = a_i ^ b_i;
      ALU_SRL:    out_o = a_i >> shamt;
      ALU_SRA:    out_o = $signed(a_i) >>> shamt;
      ALU_OR:     out_o = a_i | b_i;
      ALU_AND:    out_o = a_i & b_i;
      ALU_COPY_B: out_o = b_i;
      default:    out_o = '0;
    endcase
  end
endmodule

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [6:0]        req0_opcode,
  input  logic [2:0]        req0_funct,
  input  logic              req0_add_rshift_type,
  input  logic [DWIDTH-1:0] req0_A,
  input  logic [DWIDTH-1:0] req0_B,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [6:0]        req1_opcode,
  input  logic [2:0]        req1_funct,
  input  logic              req1_add_rshift_type,
  input  logic [DWIDTH-1:0] req1_A,
  input  logic [DWIDTH-1:0] req1_B,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_id,
  output logic [DWIDTH-1:0] res_data
);
  typedef enum logic {IDLE, RESP} state_e;

  state_e            state_q, state_d;
  logic [6:0]        opcode_q, opcode_d;
  logic [2:0]        funct_q, funct_d;
  logic              type_q, type_d;
  logic [DWIDTH-1:0] a_q, a_d, b_q, b_d;
  logic              id_q, id_d;
  logic              grant, can_accept;
  alu_op_e           alu_op;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant = req0_valid ? 1'b0 : 1'b1;
`else
  logic last_grant_q;

  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = ~req0_valid;
  end

  always_ff @(posedge clk) begin
    if (rst)             last_grant_q <= 1'b1;
    else if (req0_ready) last_grant_q <= 1'b0;
    else if (req1_ready) last_grant_q <= 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (req0_ready || req1_ready)          state_d = RESP;
    else if (state_q == RESP && res_ready) state_d = IDLE;
  end

  always_comb begin
    res_valid  = (state_q == RESP);
    can_accept = !rst && ((state_q == IDLE) || res_ready);
    req0_ready = can_accept && !grant && req0_valid;
    req1_ready = can_accept && grant && req1_valid;
  end

  always_comb begin
    opcode_d = opcode_q;
    funct_d  = funct_q;
    type_d   = type_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    if (req0_ready) begin
      opcode_d = req0_opcode;
      funct_d  = req0_funct;
      type_d   = req0_add_rshift_type;
      a_d      = req0_A;
      b_d      = req0_B;
      id_d     = 1'b0;
    end else if (req1_ready) begin
      opcode_d = req1_opcode;
      funct_d  = req1_funct;
      type_d   = req1_add_rshift_type;
      a_d      = req1_A;
      b_d      = req1_B;
      id_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q <= '0;
      funct_q  <= '0;
      type_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
    end else begin
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
      type_q   <= type_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
    end
  end

  ALUdec u_aludec (
    .opcode_i         (opcode_q),
    .funct_i          (funct_q),
    .add_rshift_type_i(type_q),
    .alu_op_o         (alu_op)
  );

  ALU #(.DWIDTH(DWIDTH)) u_alu (
    .a_i     (a_q),
    .b_i     (b_q),
    .alu_op_i(alu_op),
    .out_o   (res_data)
  );

  assign res_id = id_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic against
// a queue-based reference model. Fixed-priority checks apply when ALU_ARB_FIXED_PRIO_EN is set.
module tb_alu_arbiter;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req0_valid, req0_ready, req0_add_rshift_type;
  logic [6:0]    req0_opcode;
  logic [2:0]    req0_funct;
  logic [DW-1:0] req0_A, req0_B;
  logic          req1_valid, req1_ready, req1_add_rshift_type;
  logic [6:0]    req1_opcode;
  logic [2:0]    req1_funct;
  logic [DW-1:0] req1_A, req1_B;
  logic          res_valid, res_ready, res_id;
  logic [DW-1:0] res_data;

  alu_arbiter #(.DWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_funct(req0_funct), .req0_add_rshift_type(req0_add_rshift_type),
    .req0_A(req0_A), .req0_B(req0_B),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_funct(req1_funct), .req1_add_rshift_type(req1_add_rshift_type),
    .req1_A(req1_A), .req1_B(req1_B),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct { logic id; logic [DW-1:0] data; } res_t;
  res_t q[$];
  logic lg = 1'b1;
  logic exp_r0, exp_r1, exp_v, exp_id;
  logic [DW-1:0] exp_d;

  // Reference result, one line per RV32 integer operation.
  function automatic logic [DW-1:0] alu_ref(input logic [6:0] op, input logic [2:0] f,
                                            input logic t, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int unsigned sh;
    sh = b[4:0];
    if (op == 7'b0110111) return b;
    if (op != 7'b0110011 && op != 7'b0010011) return a + b;
    case (f)
      3'd0: return (op == 7'b0110011 && t) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 1 : 0;
      3'd3: return (a < b) ? 1 : 0;
      3'd4: return a ^ b;
      3'd5: return t ? DW'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_eval();
    logic can, g;
    exp_v  = (q.size() > 0);
    exp_id = exp_v ? q[0].id : 1'b0;
    exp_d  = exp_v ? q[0].data : '0;
    can    = !rst && (q.size() == 0 || res_ready);
`ifdef ALU_ARB_FIXED_PRIO_EN
    g = !req0_valid;
`else
    g = (req0_valid && req1_valid) ? !lg : !req0_valid;
`endif
    exp_r0 = can && req0_valid && !g;
    exp_r1 = can && req1_valid && g;
  endtask

  task automatic model_commit();
    if (rst) begin
      q.delete();
      lg = 1'b1;
    end else begin
      if (exp_v && res_ready) void'(q.pop_front());
      if (exp_r0) begin
        q.push_back('{1'b0, alu_ref(req0_opcode, req0_funct, req0_add_rshift_type, req0_A, req0_B)});
        lg = 1'b0;
      end
      if (exp_r1) begin
        q.push_back('{1'b1, alu_ref(req1_opcode, req1_funct, req1_add_rshift_type, req1_A, req1_B)});
        lg = 1'b1;
      end
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic [6:0] op, input logic [2:0] f,
                         input logic t, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (n == 0) begin
      req0_valid = v; req0_opcode = op; req0_funct = f; req0_add_rshift_type = t; req0_A = a; req0_B = b;
    end else begin
      req1_valid = v; req1_opcode = op; req1_funct = f; req1_add_rshift_type = t; req1_A = a; req1_B = b;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); model_eval(); model_commit();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; res_ready = 1'b1;
    set_req(0, 1'b1, 7'b0110011, 3'd0, 1'b0, 32'd1, 32'd2);
    set_req(1, 1'b1, 7'b0110011, 3'd4, 1'b0, 32'd3, 32'd4);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; end
      @(negedge clk); model_eval();
      n_tests++;
      if ({req0_ready, req1_ready, res_valid} !== {exp_r0, exp_r1, exp_v}) begin
        n_fail++; $display("FAIL reset cyc%0d rdy/valid got %b want %b", i, {req0_ready, req1_ready, res_valid}, {exp_r0, exp_r1, exp_v});
      end
      n_tests++;
      if ({req0_ready, req1_ready, res_valid, res_id} !== 4'b0000) begin
        n_fail++; $display("FAIL reset_idle cyc%0d rdy/valid/id got %b want 0000", i, {req0_ready, req1_ready, res_valid, res_id});
      end
      model_commit(); @(posedge clk); #1;
    end
  endtask

  task automatic test_add();
    res_ready = 1'b1;
    set_req(0, 1'b1, 7'b0110011, 3'd0, 1'b0, 32'd5, 32'd3);
    set_req(1, 1'b0, 7'b0, 3'd0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) req0_valid = 1'b0;
      @(negedge clk); model_eval();
      n_tests++;
      if ({req0_ready, req1_ready, res_valid} !== {exp_r0, exp_r1, exp_v}) begin
        n_fail++; $display("FAIL add cyc%0d rdy/valid got %b want %b", i, {req0_ready, req1_ready, res_valid}, {exp_r0, exp_r1, exp_v});
      end
      if (i == 0) begin
        n_tests++;
        if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL add_accept got %b want 1", req0_ready); end
      end
      if (i == 1) begin
        n_tests++;
        if ({res_valid, res_id, res_data} !== {1'b1, 1'b0, 32'h8}) begin
          n_fail++; $display("FAIL add_result got v=%b id=%b d=%h want v=1 id=0 d=00000008", res_valid, res_id, res_data);
        end
      end
      if (i == 2) begin
        n_tests++;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL add_idle got %b want 0", res_valid); end
      end
      model_commit(); @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] want;
    do_reset();
    res_ready = 1'b1;
    set_req(0, 1'b1, 7'b0110011, 3'd0, 1'b1, 32'd10, 32'd3);
    set_req(1, 1'b1, 7'b0110011, 3'd4, 1'b0, 32'hFF, 32'h0F);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); model_eval();
      n_tests++;
      if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL rr_grant cyc%0d got %b want %b", i, {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      if (i > 0) begin
        want = ((i - 1) % 2 == 0) ? 32'h7 : 32'hF0;
        n_tests++;
        if ({res_valid, res_data} !== {1'b1, want}) begin
          n_fail++; $display("FAIL rr_result cyc%0d got v=%b d=%h want v=1 d=%h", i, res_valid, res_data, want);
        end
      end
      model_commit(); @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 1'b0, 7'b0110011, 3'd0, 1'b0, 32'd1, 32'd1);
    set_req(1, 1'b1, 7'b0110011, 3'd5, 1'b1, 32'h80000000, 32'd4);
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin res_ready = 1'b0; req0_valid = 1'b1; end
      if (i == 5) res_ready = 1'b1;
      if (i == 6) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      @(negedge clk); model_eval();
      n_tests++;
      if ({req0_ready, req1_ready, res_valid} !== {exp_r0, exp_r1, exp_v}) begin
        n_fail++; $display("FAIL bp cyc%0d rdy/valid got %b want %b", i, {req0_ready, req1_ready, res_valid}, {exp_r0, exp_r1, exp_v});
      end
      if (exp_v) begin
        n_tests++;
        if ({res_id, res_data} !== {exp_id, exp_d}) begin
          n_fail++; $display("FAIL bp_data cyc%0d got id=%b d=%h want id=%b d=%h", i, res_id, res_data, exp_id, exp_d);
        end
      end
      if (i >= 1 && i <= 5) begin
        n_tests++;
        if ({res_valid, res_id, res_data} !== {1'b1, 1'b1, 32'hF8000000}) begin
          n_fail++; $display("FAIL bp_hold cyc%0d got v=%b id=%b d=%h want v=1 id=1 d=f8000000", i, res_valid, res_id, res_data);
        end
      end
      if (i >= 1 && i <= 4) begin
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
          n_fail++; $display("FAIL bp_stall cyc%0d ready got %b want 00", i, {req0_ready, req1_ready});
        end
      end
      model_commit(); @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_resp();
    do_reset();
    res_ready = 1'b0;
    set_req(0, 1'b1, 7'b0110011, 3'd0, 1'b0, 32'd5, 32'd3);
    set_req(1, 1'b0, 7'b0110011, 3'd0, 1'b0, 32'd9, 32'd9);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin rst = 1'b1; req1_valid = 1'b1; end
      if (i == 2) begin rst = 1'b0; res_ready = 1'b1; end
      @(negedge clk); model_eval();
      if (i == 1) begin
        n_tests++;
        if ({req0_ready, req1_ready, res_valid, res_data} !== {2'b00, 1'b1, 32'h8}) begin
          n_fail++; $display("FAIL rst_resp_hold got rdy=%b v=%b d=%h want rdy=00 v=1 d=00000008", {req0_ready, req1_ready}, res_valid, res_data);
        end
      end
      if (i == 2) begin
        n_tests++;
        if ({req0_ready, req1_ready, res_valid} !== 3'b100) begin
          n_fail++; $display("FAIL rst_resp_after got %b want 100", {req0_ready, req1_ready, res_valid});
        end
      end
      model_commit(); @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [DW-1:0] edge_vals [4];
    edge_vals[0] = 32'h0; edge_vals[1] = 32'hFFFFFFFF; edge_vals[2] = 32'h80000000; edge_vals[3] = 32'h7FFFFFFF;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++)
        set_req(n, 1'($urandom_range(0, 2) != 0),
                ($urandom_range(0, 1) != 0) ? 7'b0110011 : 7'b0010011,
                3'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom,
                ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 39) == 0);
      @(negedge clk); model_eval();
      n_tests++;
      if ({req0_ready, req1_ready, res_valid} !== {exp_r0, exp_r1, exp_v}) begin
        n_fail++; $display("FAIL rand cyc%0d rdy/valid got %b want %b", i, {req0_ready, req1_ready, res_valid}, {exp_r0, exp_r1, exp_v});
      end
      if (exp_v) begin
        n_tests++;
        if ({res_id, res_data} !== {exp_id, exp_d}) begin
          n_fail++; $display("FAIL rand_data cyc%0d got id=%b d=%h want id=%b d=%h", i, res_id, res_data, exp_id, exp_d);
        end
      end
      model_commit(); @(posedge clk); #1;
    end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

`ifdef ALU_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    do_reset();
    res_ready = 1'b1;
    set_req(0, 1'b1, 7'b0110011, 3'd0, 1'b0, 32'd1, 32'd2);
    set_req(1, 1'b1, 7'b0110011, 3'd6, 1'b0, 32'd4, 32'd8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); model_eval();
      n_tests++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
        n_fail++; $display("FAIL fixed_prio cyc%0d ready got %b want 10", i, {req0_ready, req1_ready});
      end
      model_commit(); @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; res_ready = 1'b0;
    set_req(0, 1'b0, 7'b0, 3'd0, 1'b0, '0, '0);
    set_req(1, 1'b0, 7'b0, 3'd0, 1'b0, '0, '0);
    @(posedge clk); #1;
    test_reset();
    test_add();
`ifdef ALU_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_round_robin();
    test_reset_in_resp();
`endif
    test_backpressure();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
